// File: rtl/lc3_reg_bank.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : lc3_reg_bank
// Purpose  : General-purpose register bank for the LC-3 datapath, with
//            condition-code (NZP) tracking. It holds DEPTH registers of SIZE
//            bits. It writes one destination register per clock and reads
//            two source registers combinationally.
// Revision : 1.0 - initial clocked register bank with NZP tracking
// ----------------------------------------------------------------------------
// Parameters
//   SIZE    data width of each register and of all data ports (default 16)
//   DEPTH   number of registers (default 8); AW = $clog2(DEPTH), minimum 1
// Ports
//   clk      in   1     clock, all state updates on the rising edge
//   rst_n    in   1     synchronous active-low reset
//   in       in   SIZE  write data (result bus)
//   dr       in   AW    destination register index
//   load     in   1     register write enable (LD.REG)
//   load_cc  in   1     condition-code update enable (LD.CC)
//   sr1      in   AW    source-1 register index
//   sr2      in   AW    source-2 register index
//   sr1_out  out  SIZE  contents of register sr1
//   sr2_out  out  SIZE  contents of register sr2
//   nzp      out  3     condition codes {N,Z,P}, one-hot after reset
// Build option
//   LC3_REG_BANK_FWD_EN  when defined, a write in progress is forwarded
//                        combinationally to a read port that names the same
//                        index. When undefined, a read port shows the stored
//                        contents until the edge commits the write.
// ============================================================================
module lc3_reg_bank #(
    parameter  int SIZE  = 16,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [SIZE-1:0] in,
    input  logic [AW-1:0]   dr,
    input  logic            load,
    input  logic            load_cc,
    input  logic [AW-1:0]   sr1,
    input  logic [AW-1:0]   sr2,
    output logic [SIZE-1:0] sr1_out,
    output logic [SIZE-1:0] sr2_out,
    output logic [2:0]      nzp
);

    // DEPTH expressed at the index width plus one bit. This allows an index
    // to be range-checked even when DEPTH is a power of two.
    localparam logic [AW:0] c_DEPTH   = (AW+1)'(DEPTH);

    localparam logic [2:0]  c_CC_NEG  = 3'b100;
    localparam logic [2:0]  c_CC_ZERO = 3'b010;
    localparam logic [2:0]  c_CC_POS  = 3'b001;

    logic [SIZE-1:0] r_regs [DEPTH];
    logic [2:0]      r_nzp;

    logic [DEPTH-1:0] w_we;
    logic [2:0]       w_cc_next;
    logic [SIZE-1:0]  w_sr1_raw;
    logic [SIZE-1:0]  w_sr2_raw;

    // ------------------------------------------------------------------------
    // Per-register write strobes. If dr is out of range, no strobe matches,
    // so the write is dropped and no register changes.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
            assign w_we[gi] = load && (dr == AW'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Register storage. Reset has priority over any write in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (!rst_n) begin
                r_regs[i] <= '0;
            end else if (w_we[i]) begin
                r_regs[i] <= in;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Condition codes. The value on the bus is classified as a two's
    // complement number. This does not depend on load or dr, because the
    // condition codes follow the bus value, not the register file.
    // ------------------------------------------------------------------------
    always_comb begin
        w_cc_next = c_CC_POS;
        if (in == '0) begin
            w_cc_next = c_CC_ZERO;
        end else if (in[SIZE-1]) begin
            w_cc_next = c_CC_NEG;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_nzp <= c_CC_ZERO;
        end else if (load_cc) begin
            r_nzp <= w_cc_next;
        end
    end

    assign nzp = r_nzp;

    // ------------------------------------------------------------------------
    // Read muxes. Each read is a compare against every valid index. An index
    // at or above DEPTH matches nothing and returns zero. This also avoids
    // indexing the storage array outside its bounds.
    // ------------------------------------------------------------------------
    always_comb begin
        w_sr1_raw = '0;
        w_sr2_raw = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sr1 == AW'(i)) begin
                w_sr1_raw = r_regs[i];
            end
            if (sr2 == AW'(i)) begin
                w_sr2_raw = r_regs[i];
            end
        end
    end

`ifdef LC3_REG_BANK_FWD_EN
    // Write-through bypass. This applies only to a write that will commit at
    // the next edge: reset is deasserted, load is set and dr is in range.
    logic w_wr_live;
    logic w_fwd1;
    logic w_fwd2;

    assign w_wr_live = rst_n && load && ({1'b0, dr} < c_DEPTH);
    assign w_fwd1    = w_wr_live && (sr1 == dr);
    assign w_fwd2    = w_wr_live && (sr2 == dr);

    assign sr1_out   = w_fwd1 ? in : w_sr1_raw;
    assign sr2_out   = w_fwd2 ? in : w_sr2_raw;
`else
    assign sr1_out   = w_sr1_raw;
    assign sr2_out   = w_sr2_raw;
`endif

endmodule
`default_nettype wire

// File: doc/lc3_reg_bank.md
# lc3_reg_bank

Parametrised general-purpose register bank with condition-code tracking for the LC-3 datapath; the clocked successor to the level-sensitive SIZE-wide latch. It holds DEPTH registers of SIZE bits, writes one destination register per clock, and reads two source registers combinationally. It also maintains the NZP condition-code register from the value being written. It sits between the bus/ALU result path (write side) and the ALU operand muxes (read side).

## Interface
- SIZE, 16, data width of each register and of all data ports.
- DEPTH, 8, number of registers; AW = $clog2(DEPTH) (min 1) is a derived localparam.
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset; sampled on rising clk edge.
- in  in  SIZE  write data (result bus).
- dr  in  AW  destination register index.
- load  in  1  write enable (LD.REG): store in into register dr at the edge.
- load_cc  in  1  condition-code enable (LD.CC): update nzp from in at the edge.
- sr1  in  AW  source-1 register index.
- sr2  in  AW  source-2 register index.
- sr1_out  out  SIZE  contents of register sr1.
- sr2_out  out  SIZE  contents of register sr2.
- nzp  out  3  condition codes {N,Z,P}, exactly one bit set.

## Operation
- Storage: DEPTH x SIZE flops, plus 3-bit nzp flop; no latches.
- Write: at rising clk with rst_n=1 and load=1 and dr < DEPTH, reg[dr] <= in. dr >= DEPTH (non-power-of-2 DEPTH): write dropped, no other register touched.
- Read: sr1_out/sr2_out are combinational functions of sr1/sr2 and register contents. Index >= DEPTH reads all-zeros. sr1 == sr2 is legal; both ports return the same value.
- Condition codes: at rising clk with rst_n=1 and load_cc=1: in == 0 -> nzp <= 3'b010; in[SIZE-1]=1 -> 3'b100; otherwise 3'b001. Evaluated on in as two's complement, independent of load and dr (LC-3 semantics: CC follows the bus value).
- load=0, load_cc=0: all state holds.
- Reset: rst_n=0 at a rising edge clears every register to 0 and sets nzp to 3'b010. Reset wins over simultaneous load/load_cc. Reset mid-sequence discards any write presented in that cycle.
- Reset values of outputs (after reset edge): sr1_out = 0, sr2_out = 0, nzp = 3'b010. Before the first reset edge, outputs are undefined.

## Timing
- Write latency: 1 cycle; value visible on a read port from the cycle after the writing edge.
- Read latency: 0 cycles (combinational from sr1/sr2 and state).
- nzp latency: 1 cycle after the load_cc edge; nzp never shows 3'b000 or multi-hot after reset.
- Same-cycle write and read of the same index: behaviour set by FWD_EN (see Configuration).
- No handshake; every enable is single-cycle qualified, and back-to-back writes to any indices every cycle are supported.

## Configuration
- LC3_REG_BANK_FWD_EN defined: write-through forwarding. When load=1, rst_n=1, dr < DEPTH and srX == dr, srX_out = in in the same cycle (combinational bypass). The stored value is unchanged from non-forwarded behaviour.
- Undefined: no bypass; srX_out shows the pre-write contents until the edge commits.

## Test plan
- Reset: drive rst_n=0 for one edge with load=1, dr=3, in=16'h1234 -> all registers read 0, nzp=3'b010, reg3 = 0.
- Write/read all: write reg[i] = 16'hA000+i for i=0..7 on consecutive edges, then sweep sr1=i, sr2=7-i -> sr1_out=16'hA000+i, sr2_out=16'hA007-i.
- CC: load_cc=1 with in=16'h0000, 16'h8001, 16'h7FFF on three edges -> nzp = 010, 100, 001. load_cc=0 with in=16'hFFFF -> nzp holds 001.
- Same-cycle hazard: reg2=16'h0005, then load=1, dr=2, in=16'h00FF, sr1=2 -> before the edge, sr1_out=16'h0005 without macro and 16'h00FF with LC3_REG_BANK_FWD_EN. After the edge, 16'h00FF in both builds.
- DEPTH=6 build: write dr=7 with in=16'hBEEF -> no register changes, and sr1=7 reads 16'h0000.
- Reset mid-stream: writes to reg1 every cycle, with rst_n=0 asserted for one cycle -> reg1=0 and nzp=010 after that edge, and writes resume on the next edge.
